// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the controller that
// drives it: md_op encodings, default latencies, FSM state encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;   // latencies are limited to 1..15

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that start a multi-cycle computation.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for md_unit.
// Ports:
//   op       latched md_op (MULT..DIVU meaningful, others give 0)
//   a, b     latched rs/rt operands
//   res      {HI,LO} candidate
//   div_zero high for DIV/DIVU with b == 0 (result must not be written)
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               sdiv;
  logic        [31:0] mag_a, mag_b, dvsr, uq, ur;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes, then signs are restored. This also
  // makes 0x80000000 / -1 fall out naturally as LO=0x80000000, HI=0.
  always_comb begin
    sdiv     = (op == 3'(MD_DIV));
    mag_a    = (sdiv && a[31]) ? -a : a;
    mag_b    = (sdiv && b[31]) ? -b : b;
    div_zero = ((op == 3'(MD_DIV)) || (op == 3'(MD_DIVU))) && (b == 32'd0);
    dvsr     = (b == 32'd0) ? 32'd1 : mag_b;   // keep the divider well defined
    uq       = mag_a / dvsr;
    ur       = mag_a % dvsr;
    res      = 64'd0;
    case (op)
      3'(MD_MULT):  res = prod_s;
      3'(MD_MULTU): res = prod_u;
      3'(MD_DIV):   res = {(a[31] ? -ur : ur), ((a[31] ^ b[31]) ? -uq : uq)};
      3'(MD_DIVU):  res = {ur, uq};
      default:      res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Ports:
//   clk, reset   clock; synchronous active-low reset
//   start        launch pulse, honoured in IDLE for md_op MULT..DIVU
//   md_op        operation code (see md_pkg)
//   A, B         rs / rt operands, latched at launch
//   busy         high for exactly MULT_CYCLES / DIV_CYCLES cycles
//   HI, LO       result registers
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic               launch, retire, mthi, mtlo;
  logic [63:0]        res;
  logic               div_zero;

  md_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res      (res),
    .div_zero (div_zero)
  );

  assign busy = (state == ST_RUN);

  // MTHI/MTLO win over start in IDLE; everything is ignored while running.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    retire    = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md_op == 3'(MD_MTHI)) begin
          mthi = 1'b1;
        end else if (md_op == 3'(MD_MTLO)) begin
          mtlo = 1'b1;
        end else if (start && is_md_op(md_op)) begin
          launch    = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = (md_op >= 3'(MD_DIV)) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        // Write-back happens on the edge that would take the count to 0,
        // so busy is high for exactly the loaded count.
        if (cnt == CNT_W'(1)) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= 3'(MD_NONE);
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (launch) begin
        op_q <= md_op;
        a_q  <= A;
        b_q  <= B;
      end
      if (retire && !div_zero) begin
        HI <= res[63:32];
        LO <= res[31:0];
      end
      if (mthi) HI <= A;
      if (mtlo) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  // architectural model of HI/LO
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference: MIPS semantics expressed with plain integer arithmetic.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    longint sp;
    longint unsigned up;
    sa = a; sb = b;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); {mhi, mlo} = sp; end
      3'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {mhi, mlo} = up; end
      3'd3: if (b != 0) begin
              if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                mlo = 32'h8000_0000; mhi = 32'd0;
              end else begin
                q = sa / sb; r = sa % sb; mlo = q; mhi = r;
              end
            end
      3'd4: if (b != 0) begin mlo = a / b; mhi = a % b; end
      3'd5: mhi = a;
      3'd6: mlo = a;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch an MD op and count busy cycles; inputs are scrambled after the
  // launch edge so only the latched operands can produce the result.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n, expn;
    expn = (op >= 3'd3) ? DC : MC;
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    ref_md(op, a, b);
    total++;
    if (n !== expn) begin bad++; $display("FAIL %s busy_len got=%0d exp=%0d", nm, n, expn); end
    total++;
    if (HI !== mhi) begin bad++; $display("FAIL %s HI got=%h exp=%h", nm, HI, mhi); end
    total++;
    if (LO !== mlo) begin bad++; $display("FAIL %s LO got=%h exp=%h", nm, LO, mlo); end
  endtask

  task automatic do_mt(input string nm, input logic [2:0] op, input logic st, input logic [31:0] a);
    start = st; md_op = op; A = a; B = $urandom;
    tick();
    start = 1'b0; md_op = 3'd0;
    ref_md(op, a, 32'd0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b exp=0", nm, busy); end
    total++;
    if (HI !== mhi || LO !== mlo)
      begin bad++; $display("FAIL %s HI/LO got=%h/%h exp=%h/%h", nm, HI, LO, mhi, mlo); end
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      begin bad++; $display("FAIL reset_init busy/HI/LO got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
    do_mt("pre_reset_mthi", 3'd5, 1'b0, 32'h1234);
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    mhi = 0; mlo = 0;
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      begin bad++; $display("FAIL reset busy/HI/LO got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
  endtask

  task automatic test_directed();
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3);
    total++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA)
      begin bad++; $display("FAIL mult_const got=%h/%h exp=ffffffff/fffffffa", HI, LO); end
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    total++;
    if (HI !== 32'd1 || LO !== 32'hFFFF_FFFE)
      begin bad++; $display("FAIL multu_const got=%h/%h exp=00000001/fffffffe", HI, LO); end
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    total++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD)
      begin bad++; $display("FAIL div_const got=%h/%h exp=ffffffff/fffffffd", HI, LO); end
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    total++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000)
      begin bad++; $display("FAIL div_ovf_const got=%h/%h exp=00000000/80000000", HI, LO); end
    run_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'd10);
  endtask

  task automatic test_divzero();
    do_mt("set_hi5", 3'd5, 1'b0, 32'd5);
    do_mt("set_lo9", 3'd6, 1'b0, 32'd9);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0);
    total++;
    if (HI !== 32'd5 || LO !== 32'd9)
      begin bad++; $display("FAIL divu_zero_hold got=%h/%h exp=5/9", HI, LO); end
    run_op("div_zero", 3'd3, 32'hFFFF_0000, 32'd0);
  endtask

  task automatic test_busy_interference();
    int n;
    // MTLO / MTHI during a DIV: ignored, HI/LO hold until completion
    start = 1'b1; md_op = 3'd3; A = 32'd1000; B = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd6; A = 32'hAAAA;
    tick();
    md_op = 3'd5; A = 32'hBBBB;
    total++;
    if (HI !== mhi || LO !== mlo)
      begin bad++; $display("FAIL hold_while_busy got=%h/%h exp=%h/%h", HI, LO, mhi, mlo); end
    n = 1;
    while (busy && n < 40) begin n++; tick(); end
    md_op = 3'd0;
    ref_md(3'd3, 32'd1000, 32'd7);
    total++;
    if (n !== DC) begin bad++; $display("FAIL mt_during_div busy_len got=%0d exp=%0d", n, DC); end
    total++;
    if (LO !== 32'd142 || HI !== 32'd6)
      begin bad++; $display("FAIL mt_during_div result got=%h/%h exp=6/142", HI, LO); end
    // second start mid-MULT: ignored, length unchanged
    start = 1'b1; md_op = 3'd1; A = 32'd12345; B = 32'hFFFF_FF00;
    tick();
    start = 1'b0; md_op = 3'd0; tick();
    start = 1'b1; md_op = 3'd4; A = 32'd99; B = 32'd3;
    tick();
    start = 1'b0; md_op = 3'd0;
    n = 2;
    while (busy && n < 40) begin n++; tick(); end
    ref_md(3'd1, 32'd12345, 32'hFFFF_FF00);
    total++;
    if (n !== MC) begin bad++; $display("FAIL restart_mid_mult busy_len got=%0d exp=%0d", n, MC); end
    total++;
    if (HI !== mhi || LO !== mlo)
      begin bad++; $display("FAIL restart_mid_mult result got=%h/%h exp=%h/%h", HI, LO, mhi, mlo); end
  endtask

  task automatic test_mt_idle();
    do_mt("mthi_idle", 3'd5, 1'b0, 32'hBEEF);
    total++;
    if (HI !== 32'hBEEF) begin bad++; $display("FAIL mthi_const got=%h exp=0000beef", HI); end
    do_mt("mtlo_with_start", 3'd6, 1'b1, 32'hCAFE_0001);
    do_mt("start_op0", 3'd0, 1'b1, 32'h1111_1111);
    do_mt("start_op7", 3'd7, 1'b1, 32'h2222_2222);
  endtask

  task automatic test_reset_mid_div();
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();           // now in busy cycle 3
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mhi = 0; mlo = 0;
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      begin bad++; $display("FAIL reset_mid_div got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
    repeat (DC + 2) tick();
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      begin bad++; $display("FAIL reset_no_late_wb got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random_back_to_back();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op >= 3'd1 && op <= 3'd4) run_op("rand_md", op, pick(), pick());
      else do_mt("rand_mt", op, 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b1;
    test_reset();
    test_directed();
    test_divzero();
    test_busy_interference();
    test_mt_idle();
    test_reset_mid_div();
    test_random_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
